// File: rtl/mem_wb.sv
// MEM/WB pipeline register: formats load data for the register file write port,
// flags misaligned/reserved loads and counts retired instructions.
module mem_wb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_wb_valid_i,
   input  logic              mem_wb_stall_i,
   input  logic              mem_wb_flush_i,
   input  logic              mem_wb_we_i,
   input  logic [ADDR_W-1:0] mem_wb_waddr_i,
   input  logic [DATA_W-1:0] mem_wb_alu_result_i,
   input  logic [DATA_W-1:0] mem_wb_mem_rdata_i,
   input  logic [2:0]        mem_wb_load_type_i,
   output logic              mem_wb_valid_o,
   output logic              mem_wb_we_o,
   output logic [ADDR_W-1:0] mem_wb_waddr_o,
   output logic [DATA_W-1:0] mem_wb_wdata_o,
   output logic              mem_wb_addr_err_o,
   output logic [CNT_W-1:0]  mem_wb_retire_cnt_o
);

   localparam logic [2:0] LT_NONE = 3'b000;
   localparam logic [2:0] LT_LB   = 3'b001;
   localparam logic [2:0] LT_LBU  = 3'b010;
   localparam logic [2:0] LT_LH   = 3'b011;
   localparam logic [2:0] LT_LHU  = 3'b100;
   localparam logic [2:0] LT_LW   = 3'b101;

   logic [1:0]        w_off;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [DATA_W-1:0] w_fmt;
   logic              w_err;
   logic              w_we;

   logic              r_valid;
   logic              r_we;
   logic [ADDR_W-1:0] r_waddr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_err;
   logic [CNT_W-1:0]  r_cnt;

   // Memory word is big-endian: offset 0 is the most significant lane.
   always_comb begin
      w_off = mem_wb_alu_result_i[1:0];
      case (w_off)
         2'd0:    w_byte = mem_wb_mem_rdata_i[31:24];
         2'd1:    w_byte = mem_wb_mem_rdata_i[23:16];
         2'd2:    w_byte = mem_wb_mem_rdata_i[15:8];
         default: w_byte = mem_wb_mem_rdata_i[7:0];
      endcase
      w_half = w_off[1] ? mem_wb_mem_rdata_i[15:0]
                        : mem_wb_mem_rdata_i[31:16];
      w_err = 1'b0;
      w_fmt = mem_wb_alu_result_i;
      case (mem_wb_load_type_i)
         LT_NONE: w_fmt = mem_wb_alu_result_i;
         LT_LB:   w_fmt = {{(DATA_W-8){w_byte[7]}}, w_byte};
         LT_LBU:  w_fmt = {{(DATA_W-8){1'b0}}, w_byte};
         LT_LH: begin
            w_err = w_off[0];
            w_fmt = {{(DATA_W-16){w_half[15]}}, w_half};
         end
         LT_LHU: begin
            w_err = w_off[0];
            w_fmt = {{(DATA_W-16){1'b0}}, w_half};
         end
         LT_LW: begin
            w_err = |w_off;
            w_fmt = mem_wb_mem_rdata_i;
         end
         default: w_err = 1'b1;
      endcase
      if (w_err) w_fmt = '0;
      w_we = mem_wb_valid_i & mem_wb_we_i
           & (|mem_wb_waddr_i) & ~w_err;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else if (mem_wb_flush_i) begin
         r_valid <= 1'b0;
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_err   <= 1'b0;
      end else if (!mem_wb_stall_i) begin
         r_valid <= mem_wb_valid_i;
         r_we    <= w_we;
         r_waddr <= mem_wb_waddr_i;
         r_wdata <= w_fmt;
         r_err   <= mem_wb_valid_i & w_err;
         if (mem_wb_valid_i)
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign mem_wb_valid_o      = r_valid;
   assign mem_wb_we_o         = r_we;
   assign mem_wb_waddr_o      = r_waddr;
   assign mem_wb_wdata_o      = r_wdata;
   assign mem_wb_addr_err_o   = r_err;
   assign mem_wb_retire_cnt_o = r_cnt;

endmodule

// File: tb/tb_mem_wb.sv
// Randomized self-checking bench for mem_wb against a behavioural model,
// with a second 4-bit-counter instance sharing the stimulus for wrap checks.
module tb_mem_wb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_i = 0, stall_i = 0, flush_i = 0, we_i = 0;
   logic [4:0]  waddr_i = '0;
   logic [31:0] alu_i = '0, rdata_i = '0;
   logic [2:0]  lt_i = '0;

   logic        valid_o, we_o, err_o;
   logic [4:0]  waddr_o;
   logic [31:0] wdata_o, cnt_o;
   logic        valid4, we4, err4;
   logic [4:0]  waddr4;
   logic [31:0] wdata4;
   logic [3:0]  cnt4;

   int n_tests = 0;
   int n_fail  = 0;

   bit          e_valid, e_we, e_err;
   logic [4:0]  e_waddr;
   logic [31:0] e_wdata, e_cnt;

   always #5 clk = ~clk;

   mem_wb #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .mem_wb_valid_i(valid_i), .mem_wb_stall_i(stall_i),
      .mem_wb_flush_i(flush_i), .mem_wb_we_i(we_i),
      .mem_wb_waddr_i(waddr_i), .mem_wb_alu_result_i(alu_i),
      .mem_wb_mem_rdata_i(rdata_i), .mem_wb_load_type_i(lt_i),
      .mem_wb_valid_o(valid_o), .mem_wb_we_o(we_o),
      .mem_wb_waddr_o(waddr_o), .mem_wb_wdata_o(wdata_o),
      .mem_wb_addr_err_o(err_o), .mem_wb_retire_cnt_o(cnt_o)
   );

   mem_wb #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst),
      .mem_wb_valid_i(valid_i), .mem_wb_stall_i(stall_i),
      .mem_wb_flush_i(flush_i), .mem_wb_we_i(we_i),
      .mem_wb_waddr_i(waddr_i), .mem_wb_alu_result_i(alu_i),
      .mem_wb_mem_rdata_i(rdata_i), .mem_wb_load_type_i(lt_i),
      .mem_wb_valid_o(valid4), .mem_wb_we_o(we4),
      .mem_wb_waddr_o(waddr4), .mem_wb_wdata_o(wdata4),
      .mem_wb_addr_err_o(err4), .mem_wb_retire_cnt_o(cnt4)
   );

   // Reference formatting: pick the lane by shifting the big-endian word.
   function automatic void fmt(input logic [2:0] lt, input logic [31:0] a,
                               input logic [31:0] d,
                               output logic [31:0] r, output bit e);
      int unsigned off;
      logic [31:0] b, h;
      off = a % 4;
      b = (d >> (8 * (3 - off))) & 32'hFF;
      h = (d >> (16 - 8 * off)) & 32'hFFFF;
      e = 0;
      r = 0;
      case (lt)
         3'd0: r = a;
         3'd1: r = (b >= 128) ? b - 256 : b;
         3'd2: r = b;
         3'd3: begin e = (off % 2) != 0; r = (h >= 32768) ? h - 65536 : h; end
         3'd4: begin e = (off % 2) != 0; r = h; end
         3'd5: begin e = off != 0; r = d; end
         default: e = 1;
      endcase
      if (e) r = 0;
   endfunction

   task automatic model_reset();
      e_valid = 0; e_we = 0; e_err = 0;
      e_waddr = 0; e_wdata = 0; e_cnt = 0;
   endtask

   // Drive one cycle of stimulus, advance the model, sample #1 after the edge.
   task automatic apply(input bit v, input bit st, input bit fl, input bit we,
                        input logic [4:0] wa, input logic [31:0] alu,
                        input logic [31:0] rd, input logic [2:0] lt);
      logic [31:0] r;
      bit e;
      valid_i = v; stall_i = st; flush_i = fl; we_i = we;
      waddr_i = wa; alu_i = alu; rdata_i = rd; lt_i = lt;
      if (fl) begin
         e_valid = 0; e_we = 0; e_err = 0; e_waddr = 0; e_wdata = 0;
      end else if (!st) begin
         fmt(lt, alu, rd, r, e);
         e_valid = v;
         e_waddr = wa;
         e_wdata = r;
         e_we    = v && we && wa != 0 && !e;
         e_err   = v && e;
         if (v) e_cnt = e_cnt + 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if ({valid_o, we_o, err_o, waddr_o, wdata_o, cnt_o} !== '0) begin
         n_fail++;
         $display("FAIL reset: got v=%b we=%b err=%b wa=%0d wd=%h cnt=%0d want all 0",
                  valid_o, we_o, err_o, waddr_o, wdata_o, cnt_o);
      end
   endtask

   task automatic test_alu_write();
      apply(1, 0, 0, 1, 5'd3, 32'h12345678, 32'h0, 3'd0);
      n_tests++;
      if ({we_o, waddr_o, wdata_o, cnt_o} !==
          {1'b1, 5'd3, 32'h12345678, 32'd1}) begin
         n_fail++;
         $display("FAIL alu_write: got we=%b wa=%0d wd=%h cnt=%0d want 1 3 12345678 1",
                  we_o, waddr_o, wdata_o, cnt_o);
      end
   endtask

   task automatic test_async_reset();
      apply(1, 0, 0, 1, 5'd9, 32'hCAFEF00D, 32'h0, 3'd0);
      #2 rst = 1;
      #1;
      n_tests++;
      if ({valid_o, we_o, err_o, waddr_o, wdata_o, cnt_o, cnt4} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got v=%b we=%b wa=%0d wd=%h cnt=%0d want all 0",
                  valid_o, we_o, waddr_o, wdata_o, cnt_o);
      end
      @(negedge clk);
      rst = 0;
      model_reset();
   endtask

   task automatic test_loads();
      logic [2:0]  lts [6] = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd3};
      logic [1:0]  offs[6] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0};
      logic [31:0] want[6] = '{32'hFFFFFF80, 32'h000000FF, 32'h0000007F,
                               32'h00007F01, 32'h000080FF, 32'hFFFF80FF};
      for (int i = 0; i < 6; i++) begin
         apply(1, 0, 0, 1, 5'd10, {28'h1000, 2'b00, offs[i]},
               32'h80FF7F01, lts[i]);
         n_tests++;
         if (wdata_o !== want[i] || we_o !== 1'b1 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL load[%0d]: got wd=%h we=%b err=%b want wd=%h we=1 err=0",
                     i, wdata_o, we_o, err_o, want[i]);
         end
      end
   endtask

   task automatic test_misaligned();
      logic [2:0]  lts [3] = '{3'd5, 3'd3, 3'd6};
      logic [31:0] adr [3] = '{32'h1002, 32'h1001, 32'h1000};
      logic [31:0] c0;
      for (int i = 0; i < 3; i++) begin
         c0 = cnt_o;
         apply(1, 0, 0, 1, 5'd4, adr[i], 32'hDEADBEEF, lts[i]);
         n_tests++;
         if ({we_o, err_o, wdata_o} !== {1'b0, 1'b1, 32'h0} || cnt_o !== c0 + 1) begin
            n_fail++;
            $display("FAIL misaligned[%0d]: got we=%b err=%b wd=%h cnt=%0d want 0 1 0 cnt=%0d",
                     i, we_o, err_o, wdata_o, cnt_o, c0 + 1);
         end
      end
   endtask

   task automatic test_stall_flush();
      logic [31:0] c0;
      apply(1, 0, 0, 1, 5'd7, 32'hAAAA5555, 32'h0, 3'd0);
      c0 = cnt_o;
      for (int i = 0; i < 3; i++) begin
         apply(1, 1, 0, 1, 5'($urandom), $urandom, $urandom, 3'($urandom));
         n_tests++;
         if ({valid_o, we_o, waddr_o, wdata_o, cnt_o} !==
             {1'b1, 1'b1, 5'd7, 32'hAAAA5555, c0}) begin
            n_fail++;
            $display("FAIL stall[%0d]: got v=%b we=%b wa=%0d wd=%h cnt=%0d want 1 1 7 aaaa5555 %0d",
                     i, valid_o, we_o, waddr_o, wdata_o, cnt_o, c0);
         end
      end
      apply(1, 1, 1, 1, 5'd8, 32'h1, 32'h0, 3'd0);
      n_tests++;
      if ({valid_o, we_o, err_o, waddr_o, wdata_o} !== '0 || cnt_o !== c0) begin
         n_fail++;
         $display("FAIL flush: got v=%b we=%b wa=%0d wd=%h cnt=%0d want 0 0 0 0 %0d",
                  valid_o, we_o, waddr_o, wdata_o, cnt_o, c0);
      end
   endtask

   task automatic test_r0_bubble();
      logic [31:0] c0;
      c0 = cnt_o;
      apply(1, 0, 0, 1, 5'd0, 32'h55, 32'h0, 3'd0);
      n_tests++;
      if ({we_o, valid_o, wdata_o} !== {1'b0, 1'b1, 32'h55} || cnt_o !== c0 + 1) begin
         n_fail++;
         $display("FAIL r0: got we=%b v=%b wd=%h cnt=%0d want 0 1 55 %0d",
                  we_o, valid_o, wdata_o, cnt_o, c0 + 1);
      end
      apply(0, 0, 0, 1, 5'd6, 32'h66, 32'h0, 3'd0);
      n_tests++;
      if ({we_o, valid_o, err_o} !== 3'b000 || cnt_o !== c0 + 1) begin
         n_fail++;
         $display("FAIL bubble: got we=%b v=%b err=%b cnt=%0d want 0 0 0 %0d",
                  we_o, valid_o, err_o, cnt_o, c0 + 1);
      end
   endtask

   task automatic test_random();
      int errs = 0;
      for (int i = 0; i < 400; i++) begin
         apply($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0,
               5'($urandom), $urandom, $urandom, 3'($urandom));
         n_tests++;
         if ({valid_o, we_o, err_o, waddr_o, wdata_o, cnt_o, cnt4} !==
             {e_valid, e_we, e_err, e_waddr, e_wdata, e_cnt, e_cnt[3:0]}) begin
            n_fail++;
            if (errs++ < 10)
               $display("FAIL random[%0d]: got v=%b we=%b err=%b wa=%0d wd=%h cnt=%0d c4=%0d want %b %b %b %0d %h %0d %0d",
                        i, valid_o, we_o, err_o, waddr_o, wdata_o, cnt_o, cnt4,
                        e_valid, e_we, e_err, e_waddr, e_wdata, e_cnt, e_cnt[3:0]);
         end
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 17; i++)
         apply(1, 0, 0, 1, 5'd1, $urandom, $urandom, 3'd0);
      n_tests++;
      if (cnt4 !== 4'd1 || cnt_o !== 32'd17) begin
         n_fail++;
         $display("FAIL wrap: got cnt4=%0d cnt32=%0d want 1 17", cnt4, cnt_o);
      end
   endtask

   initial begin
      model_reset();
      @(posedge clk);
      #1;
      test_reset();
      test_alu_write();
      test_async_reset();
      test_loads();
      test_misaligned();
      test_stall_flush();
      test_r0_bubble();
      test_random();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
